// File: rtl/ahb_lite_pkg.sv
// Shared AHB-lite encodings, SRAM controller state codes and byte-lane helpers.
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_WR   = 3'd2;
    localparam logic [2:0] ST_ERR1 = 3'd3;
    localparam logic [2:0] ST_ERR2 = 3'd4;

    function automatic logic [3:0] byte_mask(input logic [2:0] size, input logic [1:0] a);
        case (size)
            HSIZE_BYTE: byte_mask = 4'b0001 << a;
            HSIZE_HALF: byte_mask = a[1] ? 4'b1100 : 4'b0011;
            default:    byte_mask = 4'hF;
        endcase
    endfunction

    function automatic logic size_illegal(input logic [2:0] size, input logic [1:0] a);
        size_illegal = (size > HSIZE_WORD)
                    || (size == HSIZE_HALF && a[0])
                    || (size == HSIZE_WORD && a != 2'b00);
    endfunction

endpackage

// File: rtl/ahb_sram_wbuf.sv
// One-entry write buffer with read-address compare and byte-wise forwarding
// into the read data returned during the RD cycle.
module ahb_sram_wbuf #(
    parameter int AW = 15
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic          drain_i,
    input  logic [31:0]   wdata_i,
    input  logic [3:0]    mask_i,
    input  logic [AW-1:0] addr_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    input  logic [31:0]   sram_rdata_i,
    output logic          valid_o,
    output logic [31:0]   data_o,
    output logic [3:0]    mask_o,
    output logic [AW-1:0] addr_o,
    output logic [31:0]   rdata_o
);

    logic          vld_q, vld_d;
    logic [31:0]   data_q;
    logic [3:0]    mask_q;
    logic [AW-1:0] addr_q;
    logic          hit;

    // A load in the same cycle as a drain keeps the entry valid with the new write.
    assign vld_d = load_i | (vld_q & ~drain_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (load_i) begin
            data_q <= wdata_i;
            mask_q <= mask_i;
            addr_q <= addr_i;
        end
    end

    assign hit = vld_q & (addr_q == rd_addr_i);

    always_comb begin
        rdata_o = 32'h0;
        if (rd_en_i) begin
            for (int i = 0; i < 4; i++) begin
                rdata_o[8*i +: 8] = (hit && mask_q[i]) ? data_q[8*i +: 8] : sram_rdata_i[8*i +: 8];
            end
        end
    end

    assign valid_o = vld_q;
    assign data_o  = data_q;
    assign mask_o  = mask_q;
    assign addr_o  = addr_q;

endmodule

// File: rtl/ahb_sram_ctrl.sv
// Zero-wait-state AHB-lite to synchronous SRAM bridge; reads use the SRAM port
// in their address phase, so colliding write data phases go through a write buffer.
module ahb_sram_ctrl
    import ahb_lite_pkg::*;
#(
    parameter int AW = 15
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic [31:0]   HWDATA,
    input  logic          HREADY,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [31:0]   HRDATA,
    input  logic [31:0]   SRAMRDATA,
    output logic [3:0]    SRAMWEN,
    output logic [31:0]   SRAMWDATA,
    output logic          SRAMCS0,
    output logic [AW-1:0] SRAMADDR
);

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] addr_q;
    logic [3:0]    mask_q;
    logic          trans_active, accept, illegal, rd_acc, in_wr, in_rd;
    logic          buf_vld, buf_load, buf_drain;
    logic [31:0]   buf_data;
    logic [3:0]    buf_mask;
    logic [AW-1:0] buf_addr;
    logic          unused_addr_hi;

    assign unused_addr_hi = ^HADDR[31:AW+2];

    // HRESETn gating keeps the SRAM port quiet while reset is held.
    assign trans_active = (HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ);
    assign accept  = HRESETn & HSEL & HREADY & trans_active & (state_q != ST_ERR1);
    assign illegal = size_illegal(HSIZE, HADDR[1:0]);
    assign rd_acc  = accept & ~illegal & ~HWRITE;
    assign in_wr   = (state_q == ST_WR);
    assign in_rd   = (state_q == ST_RD);

    always_comb begin
        state_d = ST_IDLE;
        if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end else if (accept) begin
            state_d = illegal ? ST_ERR1 : (HWRITE ? ST_WR : ST_RD);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge HCLK) begin
        if (accept) begin
            addr_q <= HADDR[AW+1:2];
            mask_q <= byte_mask(HSIZE, HADDR[1:0]);
        end
    end

    // Buffer drains whenever no read owns the port; a write data phase that
    // cannot go straight to the SRAM takes the buffer slot instead.
    assign buf_drain = buf_vld & ~rd_acc;
    assign buf_load  = in_wr & (rd_acc | buf_vld);

    always_comb begin
        SRAMCS0   = 1'b0;
        SRAMWEN   = 4'h0;
        SRAMADDR  = HADDR[AW+1:2];
        SRAMWDATA = HWDATA;
        if (rd_acc) begin
            SRAMCS0 = 1'b1;
        end else if (buf_vld) begin
            SRAMCS0   = 1'b1;
            SRAMWEN   = buf_mask;
            SRAMADDR  = buf_addr;
            SRAMWDATA = buf_data;
        end else if (in_wr) begin
            SRAMCS0  = 1'b1;
            SRAMWEN  = mask_q;
            SRAMADDR = addr_q;
        end
    end

    assign HREADYOUT = (state_q != ST_ERR1);
    assign HRESP     = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;

    ahb_sram_wbuf #(.AW(AW)) u_wbuf (
        .clk_i        (HCLK),
        .rst_ni       (HRESETn),
        .load_i       (buf_load),
        .drain_i      (buf_drain),
        .wdata_i      (HWDATA),
        .mask_i       (mask_q),
        .addr_i       (addr_q),
        .rd_en_i      (in_rd),
        .rd_addr_i    (addr_q),
        .sram_rdata_i (SRAMRDATA),
        .valid_o      (buf_vld),
        .data_o       (buf_data),
        .mask_o       (buf_mask),
        .addr_o       (buf_addr),
        .rdata_o      (HRDATA)
    );

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Directed bench for ahb_sram_ctrl with a behavioural one-cycle-latency SRAM.
module tb_ahb_sram_ctrl;

    localparam int AW = 15;
    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NS   = 2'b10;
    localparam logic [2:0] SZ_B = 3'd0;
    localparam logic [2:0] SZ_H = 3'd1;
    localparam logic [2:0] SZ_W = 3'd2;

    logic          HCLK, HRESETn, HSEL, HWRITE, HREADY, HREADYOUT, HRESP, SRAMCS0;
    logic [31:0]   HADDR, HWDATA, HRDATA, SRAMRDATA, SRAMWDATA;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic [3:0]    SRAMWEN;
    logic [AW-1:0] SRAMADDR;

    logic [31:0] mem [0:(1<<AW)-1];
    int n_chk = 0;
    int n_err = 0;
    int rst_wr_cnt = 0;

    logic [31:0]   o_rdata, o_wdata;
    logic          o_rdy, o_resp, o_cs;
    logic [3:0]    o_wen;
    logic [AW-1:0] o_addr;

    assign HREADY = HREADYOUT;

    ahb_sram_ctrl #(.AW(AW)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .SRAMRDATA (SRAMRDATA),
        .SRAMWEN   (SRAMWEN),
        .SRAMWDATA (SRAMWDATA),
        .SRAMCS0   (SRAMCS0),
        .SRAMADDR  (SRAMADDR)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    always @(posedge HCLK) begin : sram_model
        logic [31:0] w;
        if (SRAMCS0) begin
            w = mem[SRAMADDR];
            for (int b = 0; b < 4; b++) begin
                if (SRAMWEN[b]) w[8*b +: 8] = SRAMWDATA[8*b +: 8];
            end
            mem[SRAMADDR] <= w;
            SRAMRDATA     <= mem[SRAMADDR];
        end
        if (!HRESETn && SRAMCS0 && (SRAMWEN != 4'h0)) rst_wr_cnt <= rst_wr_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sample();
        o_rdata = HRDATA;
        o_rdy   = HREADYOUT;
        o_resp  = HRESP;
        o_cs    = SRAMCS0;
        o_wen   = SRAMWEN;
        o_addr  = SRAMADDR;
        o_wdata = SRAMWDATA;
    endtask

    // Drives one address phase plus the data of the previous transfer, samples mid-cycle.
    task automatic bus(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
        HTRANS = tr;
        HWRITE = wr;
        HSIZE  = sz;
        HADDR  = a;
        HWDATA = wd;
        @(negedge HCLK);
        sample();
        @(posedge HCLK);
        #1;
    endtask

    logic        s_wr [8];
    logic [2:0]  s_sz [8];
    logic [31:0] s_ad [8];
    logic [31:0] s_wd [8];
    logic [31:0] s_ex [8];

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
        SRAMRDATA = 32'h0;
        HRESETn = 1'b0;
        HSEL    = 1'b1;
        HTRANS  = T_NS;
        HWRITE  = 1'b0;
        HSIZE   = SZ_W;
        HADDR   = 32'h10;
        HWDATA  = 32'h0;

        // Reset state with a read address phase presented
        @(negedge HCLK);
        sample();
        chk("rst_rdy",   32'(o_rdy),  32'h1);
        chk("rst_resp",  32'(o_resp), 32'h0);
        chk("rst_rdata", o_rdata,     32'h0);
        chk("rst_cs",    32'(o_cs),   32'h0);
        chk("rst_wen",   32'(o_wen),  32'h0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

        // Basic write then read, plus BUSY with no access
        bus(T_BUSY, 1'b0, SZ_W, 32'h10, 32'h0);
        chk("busy_cs",  32'(o_cs),  32'h0);
        chk("busy_rdy", 32'(o_rdy), 32'h1);
        bus(T_NS, 1'b1, SZ_W, 32'h10, 32'h0);
        bus(T_IDLE, 1'b0, SZ_W, 32'h0, 32'hDEADBEEF);
        chk("wr_wen",   32'(o_wen),  32'hF);
        chk("wr_addr",  32'(o_addr), 32'h4);
        chk("wr_wdata", o_wdata,     32'hDEADBEEF);
        chk("wr_rdy",   32'(o_rdy),  32'h1);
        bus(T_NS, 1'b0, SZ_W, 32'h10, 32'h0);
        chk("rd_cs",  32'(o_cs),  32'h1);
        chk("rd_wen", 32'(o_wen), 32'h0);
        bus(T_IDLE, 1'b0, SZ_W, 32'h0, 32'h0);
        chk("rd_data", o_rdata,     32'hDEADBEEF);
        chk("rd_rdy",  32'(o_rdy),  32'h1);
        chk("rd_resp", 32'(o_resp), 32'h0);

        // Write data phase colliding with read of same address: forwarding
        bus(T_NS, 1'b1, SZ_W, 32'h20, 32'h0);
        bus(T_NS, 1'b0, SZ_W, 32'h20, 32'h11223344);
        chk("fwd_nowr", 32'(o_wen), 32'h0);
        chk("fwd_rdcs", 32'(o_cs),  32'h1);
        bus(T_IDLE, 1'b0, SZ_W, 32'h0, 32'h0);
        chk("fwd_data",  o_rdata,     32'h11223344);
        chk("drain_wen", 32'(o_wen),  32'hF);
        chk("drain_adr", 32'(o_addr), 32'h8);
        chk("drain_wd",  o_wdata,     32'h11223344);
        bus(T_NS, 1'b0, SZ_W, 32'h20, 32'h0);
        bus(T_IDLE, 1'b0, SZ_W, 32'h0, 32'h0);
        chk("after_drain", o_rdata, 32'h11223344);

        // Byte write lane 3, then forwarded byte write lane 1
        bus(T_NS, 1'b1, SZ_B, 32'h23, 32'h0);
        bus(T_IDLE, 1'b0, SZ_W, 32'h0, 32'hAA000000);
        chk("byte_wen", 32'(o_wen), 32'h8);
        bus(T_NS, 1'b0, SZ_W, 32'h20, 32'h0);
        bus(T_IDLE, 1'b0, SZ_W, 32'h0, 32'h0);
        chk("byte_rd", o_rdata, 32'hAA223344);
        bus(T_NS, 1'b1, SZ_B, 32'h21, 32'h0);
        bus(T_NS, 1'b0, SZ_W, 32'h20, 32'h0000BB00);
        bus(T_IDLE, 1'b0, SZ_W, 32'h0, 32'h0);
        chk("bfwd_rd",  o_rdata,    32'hAA22BB44);
        chk("bfwd_wen", 32'(o_wen), 32'h2);

        // Illegal transfers: misaligned word, size 3, misaligned halfword read
        bus(T_NS, 1'b1, SZ_W, 32'h22, 32'h0);
        bus(T_IDLE, 1'b0, SZ_W, 32'h0, 32'hFFFFFFFF);
        chk("e1a_rdy",  32'(o_rdy),  32'h0);
        chk("e1a_resp", 32'(o_resp), 32'h1);
        chk("e1a_wen",  32'(o_wen),  32'h0);
        bus(T_IDLE, 1'b0, SZ_W, 32'h0, 32'hFFFFFFFF);
        chk("e2a_rdy",  32'(o_rdy),  32'h1);
        chk("e2a_resp", 32'(o_resp), 32'h1);
        bus(T_NS, 1'b1, 3'd3, 32'h20, 32'h0);
        bus(T_IDLE, 1'b0, SZ_W, 32'h0, 32'hFFFFFFFF);
        chk("e1b_rdy",  32'(o_rdy),  32'h0);
        chk("e1b_resp", 32'(o_resp), 32'h1);
        chk("e1b_wen",  32'(o_wen),  32'h0);
        bus(T_IDLE, 1'b0, SZ_W, 32'h0, 32'hFFFFFFFF);
        chk("e2b_rdy",  32'(o_rdy),  32'h1);
        chk("e2b_resp", 32'(o_resp), 32'h1);
        bus(T_NS, 1'b0, SZ_H, 32'h21, 32'h0);
        chk("e_h_cs", 32'(o_cs), 32'h0);
        bus(T_IDLE, 1'b0, SZ_W, 32'h0, 32'h0);
        chk("e1c_rdy", 32'(o_rdy), 32'h0);
        bus(T_IDLE, 1'b0, SZ_W, 32'h0, 32'h0);
        chk("e2c_resp", 32'(o_resp), 32'h1);
        bus(T_NS, 1'b0, SZ_W, 32'h20, 32'h0);
        bus(T_IDLE, 1'b0, SZ_W, 32'h0, 32'h0);
        chk("err_nochg", o_rdata, 32'hAA22BB44);

        // Back-to-back alternating write/read stream
        s_wr = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        s_sz = '{SZ_W, SZ_W, SZ_H, SZ_W, SZ_B, SZ_W, SZ_W, SZ_W};
        s_ad = '{32'h40, 32'h40, 32'h46, 32'h44, 32'h49, 32'h48, 32'h4C, 32'h4C};
        s_wd = '{32'hA0A1A2A3, 32'h0, 32'hB0B1B2B3, 32'h0, 32'hC0C1C2C3, 32'h0, 32'hE0E1E2E3, 32'h0};
        s_ex = '{32'h0, 32'hA0A1A2A3, 32'h0, 32'hB0B10000, 32'h0, 32'h0000C200, 32'h0, 32'hE0E1E2E3};
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) bus(T_NS, s_wr[i], s_sz[i], s_ad[i], (i > 0) ? s_wd[i-1] : 32'h0);
            else       bus(T_IDLE, 1'b0, SZ_W, 32'h0, 32'h0);
            chk($sformatf("strm_rdy%0d", i),  32'(o_rdy),  32'h1);
            chk($sformatf("strm_resp%0d", i), 32'(o_resp), 32'h0);
            if (i > 0 && !s_wr[i-1]) chk($sformatf("strm_rd%0d", i-1), o_rdata, s_ex[i-1]);
        end

        // Reset while the buffer holds a write
        bus(T_NS, 1'b1, SZ_W, 32'h60, 32'h0);
        bus(T_IDLE, 1'b0, SZ_W, 32'h0, 32'h12345678);
        bus(T_NS, 1'b1, SZ_W, 32'h60, 32'h0);
        bus(T_NS, 1'b0, SZ_W, 32'h60, 32'h99999999);
        HRESETn = 1'b0;
        HTRANS  = T_IDLE;
        @(negedge HCLK);
        sample();
        chk("rst2_rdy",   32'(o_rdy),  32'h1);
        chk("rst2_resp",  32'(o_resp), 32'h0);
        chk("rst2_rdata", o_rdata,     32'h0);
        chk("rst2_cs",    32'(o_cs),   32'h0);
        chk("rst2_wen",   32'(o_wen),  32'h0);
        @(posedge HCLK);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        bus(T_NS, 1'b0, SZ_W, 32'h60, 32'h0);
        bus(T_IDLE, 1'b0, SZ_W, 32'h0, 32'h0);
        chk("rst2_old", o_rdata, 32'h12345678);
        chk("rst_nowr", 32'(rst_wr_cnt), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ahb_sram_ctrl.md
AHB_SRAM_CTRL -- requirements
Module: ahb_sram_ctrl

Interface
REQ-001 SHALL have parameter AW, default 15, the SRAM word-address width.
REQ-002 SHALL have port HCLK  in  1  the single clock; all logic is rising-edge.
REQ-003 SHALL have port HRESETn  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have AHB-lite slave ports:
  - HSEL in 1, slave select.
  - HADDR in 32, byte address.
  - HTRANS in 2, transfer type.
  - HWRITE in 1, write/read.
  - HSIZE in 3, access size.
  - HWDATA in 32, write data.
  - HREADY in 1, bus ready.
  - HREADYOUT out 1, slave ready.
  - HRESP out 1, 1 = ERROR.
  - HRDATA out 32, read data.
REQ-005 SHALL have SRAM ports:
  - SRAMRDATA in 32, read data, valid one cycle after the SRAM access.
  - SRAMWEN out 4, per-byte write enables.
  - SRAMWDATA out 32, write data.
  - SRAMCS0 out 1, enable.
  - SRAMADDR out AW, word address.

Function
REQ-006 SHALL accept an address phase only when HSEL=1, HREADY=1 and HTRANS[1]=1; IDLE and BUSY transfers SHALL get zero-wait OKAY and cause no SRAM access.
REQ-007 SHALL flag as illegal: HSIZE>2, halfword with HADDR[0]=1, word with HADDR[1:0]!=0.
REQ-008 SHALL answer an illegal transfer with a two-cycle ERROR and no SRAM write:
  - cycle 1: HREADYOUT=0, HRESP=1.
  - cycle 2: HREADYOUT=1, HRESP=1.
REQ-009 SHALL use a state machine with states IDLE, RD, WR, ERR1, ERR2.
  - Accepted legal read -> RD.
  - Accepted legal write -> WR.
  - Accepted illegal transfer -> ERR1 -> ERR2.
  - Otherwise -> IDLE.
  - RD, WR and ERR2 SHALL re-evaluate the bus on the same edge (back-to-back transfers).
REQ-010 SHALL give legal transfers zero wait states: HREADYOUT=1 and HRESP=0 in RD and WR.
REQ-011 SHALL issue a read combinationally in its address phase: SRAMCS0=1, SRAMWEN=0, SRAMADDR=HADDR[AW+1:2].
  - HRDATA in the RD cycle SHALL be SRAMRDATA, byte-merged with any forwarded buffer data (REQ-014).
  - HRDATA SHALL be 0 outside RD.
REQ-012 SHALL derive the byte mask from HSIZE and HADDR[1:0]:
  - byte: one lane, selected by HADDR[1:0].
  - halfword: lanes 1:0 or 3:2, selected by HADDR[1].
  - word: 4'hF.
REQ-013 SHALL handle write data in the WR cycle:
  - SRAM port free (no read address phase accepted this cycle): write HWDATA directly, SRAMWEN=mask.
  - SRAM port busy: load HWDATA, mask and word address into a one-entry write buffer.
REQ-014 SHALL manage the write buffer:
  - drain it on the first cycle the SRAM port is free, with priority over a direct write (the direct write is then buffered instead).
  - merge, byte-wise, any valid buffer entry whose address matches the registered read address into HRDATA during RD, whether or not the buffer drains that cycle.
REQ-015 SHALL never overflow the buffer or insert wait states; a write data phase with a full buffer SHALL drain the buffer and store the new write in the same cycle.
REQ-016 SHALL ignore HADDR bits above AW+1 (aliasing).
REQ-017 SHALL allow the buffer to drain during ERR1 and ERR2.

Reset
REQ-018 SHALL drive on reset: HREADYOUT=1, HRESP=0, HRDATA=0, SRAMCS0=0, SRAMWEN=0, state IDLE, buffer invalid.
REQ-019 SHALL drop a buffered or in-flight write on reset; no SRAM write SHALL occur while HRESETn=0.

Structure
REQ-020 SHALL take HTRANS/HSIZE/HRESP encodings and the state enum from the shared package ahb_lite_pkg.
REQ-021 SHALL place the buffer, address compare and byte merge in the sub-module ahb_sram_wbuf.

Verification
REQ-022 Word write 0xDEADBEEF to 0x10, then read 0x10 -> HRDATA=0xDEADBEEF, zero wait states, HRESP=0 throughout.
REQ-023 Write word 0x11223344 to 0x20 with its data phase overlapping a read address phase of 0x20 -> buffer loads, read returns 0x11223344 via forwarding, SRAM write occurs on the next free cycle.
REQ-024 Byte write 0xAA to 0x23 over word 0x11223344 -> SRAMWEN=4'b1000; read 0x20 returns 0xAA223344.
REQ-025 Word access at 0x22, then HSIZE=3 -> each gives HREADYOUT 0 then 1 with HRESP=1 both cycles, and the SRAM content is unchanged.
REQ-026 Alternating write/read stream of 8 transfers -> every read matches a reference model, no HREADYOUT low.
REQ-027 HRESETn low with the buffer valid -> outputs at reset values; a later read returns the old SRAM data.
